digit_entry_loader: RTL and testbench
=====================================

# digit_entry_loader

Keypad-side writer for the BCD down-counter chain of the timer. It collects decimal key presses into a 3-digit minutes:seconds entry (M:ST:SU). On a start request it validates the entry and drives the counters' synchronous parallel-load interface: a 4-bit `data` bus per digit plus an active-low `loadn` pulse. It sits between the keypad encoder and the three cascaded mod-10/mod-6 down-counters, and is gated off while the chain is counting.

## Interface
Parameters:
- `MAX_SEC_TENS`, default 5: largest legal seconds-tens digit; larger values are rejected at start.

Ports:
- `clock`  in  1  system clock, all state on rising edge
- `clearn`  in  1  asynchronous reset, active low
- `key_code`  in  4  BCD digit from keypad encoder, meaningful while `key_valid`=1
- `key_valid`  in  1  level, high while a key is held
- `start`  in  1  level start request, rising-edge detected
- `cancel`  in  1  level clear-entry request, rising-edge detected
- `counting`  in  1  high while the counter chain is running
- `data_min`  out  4  minutes digit to counter `data`
- `data_sec_tens`  out  4  seconds-tens digit to counter `data`
- `data_sec_units`  out  4  seconds-units digit to counter `data`
- `loadn`  out  1  active-low load strobe to all three counters
- `digits_entered`  out  2  number of digits entered, saturates at 3
- `err`  out  1  one-cycle pulse on rejected start

## Operation
- Reset (async, `clearn`=0):
  - all `data_*` = 0, `digits_entered` = 0.
  - `loadn` = 1, `err` = 0, FSM = IDLE.
  - edge-detect history registers = 0.
  - A `clearn` assertion during LOAD forces `loadn` high immediately.
- Edge detect: each of `key_valid`, `start` and `cancel` has a 1-cycle history register. An event fires at a posedge where the input is 1 and its history is 0.
  - A key held through reset release counts as one press.
- FSM states:
  - IDLE: accepts entry events; `loadn`=1.
  - LOAD: lasts exactly one cycle; `loadn`=0; `data_*` frozen; all events ignored; always returns to IDLE.
- Key event in IDLE, `counting`=0, `key_code`≤9:
  - shift left: `data_min`←`data_sec_tens`, `data_sec_tens`←`data_sec_units`, `data_sec_units`←`key_code`.
  - The old minutes digit is discarded.
  - `digits_entered` increments and saturates at 3.
- Key event with `key_code`>9: ignored, no state change.
- Cancel event in IDLE: clear all `data_*` and `digits_entered` to 0.
- Start event in IDLE, `counting`=0:
  - entry all zero: ignored, no `loadn`, no `err`.
  - `data_sec_tens` > `MAX_SEC_TENS`: `err`=1 for one cycle; entry cleared; stays IDLE.
  - otherwise: go to LOAD.
- Leaving LOAD: at that posedge clear all `data_*` and `digits_entered` to 0.
- `counting`=1: all key, start and cancel events are dropped. History registers still update, so a key held across the falling edge of `counting` does not fire.
- Same-cycle priority: cancel > start > key.
  - The losing events are consumed, not deferred.

## Timing
- Key: a rising edge of `key_valid` sampled at posedge N updates `data_*` and `digits_entered` at posedge N.
- Start: a `start` rising edge sampled at posedge N moves the FSM to LOAD at posedge N.
  - `loadn` is low from just after N until just after N+1.
  - The counters capture `data_*` at posedge N+1, which are still the entered values.
  - The entry clears at N+1.
- `err` is registered: high for the single cycle following the rejecting posedge.
- Minimum spacing between two loads is 2 cycles; a start held high produces only one load.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, press 1, 3, 0, then start → `data` = 1:3:0 while `loadn`=0 for exactly one cycle, then 0:0:0 and `digits_entered`=0.
- Press 9, 4, 5, 2 → oldest digit dropped: `data` = 4:5:2, `digits_entered`=3; `key_code`=0xC press leaves it unchanged.
- Press 0, 7, 5, then start → `err` pulses one cycle, `loadn` stays 1, entry cleared. Start with an all-zero entry → no `loadn`, no `err`.
- Same cycle: start and cancel edges → entry cleared, no load. Same cycle: start and key edges → load of the prior entry, key dropped.
- `counting`=1, then key and start pulses → no change; drop `counting` while the key is held → no press registered.
- Assert `clearn` during the LOAD cycle → `loadn` returns to 1 asynchronously, all outputs at reset values.

Source files
------------

// File: rtl/digit_entry_loader.sv
// Keypad digit collector for the M:ST:SU BCD down-counter chain.
// Builds a shifted 3-digit entry and issues a one-cycle active-low parallel load on start.
module digit_entry_loader #(
    parameter int unsigned MAX_SEC_TENS = 5
) (
    input  logic       clock,
    input  logic       clearn,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    input  logic       start,
    input  logic       cancel,
    input  logic       counting,
    output logic [3:0] data_min,
    output logic [3:0] data_sec_tens,
    output logic [3:0] data_sec_units,
    output logic       loadn,
    output logic [1:0] digits_entered,
    output logic       err
);

    localparam logic [3:0] MAX_TENS = 4'(MAX_SEC_TENS);

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t state;

    logic key_q;
    logic start_q;
    logic cancel_q;

    logic key_ev;
    logic start_ev;
    logic cancel_ev;
    logic entry_zero;

    assign key_ev     = key_valid & ~key_q;
    assign start_ev   = start & ~start_q;
    assign cancel_ev  = cancel & ~cancel_q;
    assign entry_zero = (data_min == 4'd0) && (data_sec_tens == 4'd0) && (data_sec_units == 4'd0);

    // History registers update every cycle, so events that arrive while counting
    // or during LOAD are consumed rather than replayed later.
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            state          <= IDLE;
            key_q          <= 1'b0;
            start_q        <= 1'b0;
            cancel_q       <= 1'b0;
            data_min       <= 4'd0;
            data_sec_tens  <= 4'd0;
            data_sec_units <= 4'd0;
            digits_entered <= 2'd0;
            loadn          <= 1'b1;
            err            <= 1'b0;
        end else begin
            key_q    <= key_valid;
            start_q  <= start;
            cancel_q <= cancel;
            err      <= 1'b0;

            case (state)
                IDLE: begin
                    loadn <= 1'b1;
                    if (!counting) begin
                        if (cancel_ev) begin
                            data_min       <= 4'd0;
                            data_sec_tens  <= 4'd0;
                            data_sec_units <= 4'd0;
                            digits_entered <= 2'd0;
                        end else if (start_ev) begin
                            if (entry_zero) begin
                                state <= IDLE;
                            end else if (data_sec_tens > MAX_TENS) begin
                                err            <= 1'b1;
                                data_min       <= 4'd0;
                                data_sec_tens  <= 4'd0;
                                data_sec_units <= 4'd0;
                                digits_entered <= 2'd0;
                            end else begin
                                state <= LOAD;
                                loadn <= 1'b0;
                            end
                        end else if (key_ev && (key_code <= 4'd9)) begin
                            data_min       <= data_sec_tens;
                            data_sec_tens  <= data_sec_units;
                            data_sec_units <= key_code;
                            if (digits_entered != 2'd3) begin
                                digits_entered <= digits_entered + 2'd1;
                            end
                        end
                    end
                end

                // The counters sample data_* on the edge that ends this state,
                // so the entry is cleared on that same edge.
                LOAD: begin
                    state          <= IDLE;
                    loadn          <= 1'b1;
                    data_min       <= 4'd0;
                    data_sec_tens  <= 4'd0;
                    data_sec_units <= 4'd0;
                    digits_entered <= 2'd0;
                end

                default: begin
                    state <= IDLE;
                    loadn <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_entry_loader.sv
// Directed bench for digit_entry_loader: entry shifting, validation, load strobe,
// event priority, counting gate and asynchronous reset during LOAD.
module tb_digit_entry_loader;

    logic       clock;
    logic       clearn;
    logic [3:0] key_code;
    logic       key_valid;
    logic       start;
    logic       cancel;
    logic       counting;
    logic [3:0] data_min;
    logic [3:0] data_sec_tens;
    logic [3:0] data_sec_units;
    logic       loadn;
    logic [1:0] digits_entered;
    logic       err;

    int evaluated = 0;
    int failures  = 0;

    digit_entry_loader #(.MAX_SEC_TENS(5)) dut (
        .clock          (clock),
        .clearn         (clearn),
        .key_code       (key_code),
        .key_valid      (key_valid),
        .start          (start),
        .cancel         (cancel),
        .counting       (counting),
        .data_min       (data_min),
        .data_sec_tens  (data_sec_tens),
        .data_sec_units (data_sec_units),
        .loadn          (loadn),
        .digits_entered (digits_entered),
        .err            (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] kc, input logic kv, input logic st,
                                 input logic cn, input logic ct);
        key_code  = kc;
        key_valid = kv;
        start     = st;
        cancel    = cn;
        counting  = ct;
    endtask

    // Observed/expected packed as {min, tens, units, loadn, digits_entered, err}.
    task automatic checkOutput(input string tag, input logic [3:0] emin, input logic [3:0] etens,
                               input logic [3:0] eunits, input logic eloadn,
                               input logic [1:0] ecnt, input logic eerr);
        logic [15:0] obs;
        logic [15:0] exp;
        obs = {data_min, data_sec_tens, data_sec_units, loadn, digits_entered, err};
        exp = {emin, etens, eunits, eloadn, ecnt, eerr};
        evaluated++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] kc);
        applyStimulus(kc, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(kc, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        clearn = 1'b0;
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #12;
        checkOutput("reset", 4'd0, 4'd0, 4'd0, 1'b1, 2'd0, 1'b0);
        clearn = 1'b1;
        tick();
        checkOutput("after_release", 4'd0, 4'd0, 4'd0, 1'b1, 2'd0, 1'b0);

        $display("[TB] entry 1 3 0 and load");
        press(4'd1);
        checkOutput("key1", 4'd0, 4'd0, 4'd1, 1'b1, 2'd1, 1'b0);
        press(4'd3);
        press(4'd0);
        checkOutput("entry_130", 4'd1, 4'd3, 4'd0, 1'b1, 2'd3, 1'b0);
        applyStimulus(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("load_130", 4'd1, 4'd3, 4'd0, 1'b0, 2'd3, 1'b0);
        tick();
        checkOutput("load_end", 4'd0, 4'd0, 4'd0, 1'b1, 2'd0, 1'b0);
        tick();
        checkOutput("start_held", 4'd0, 4'd0, 4'd0, 1'b1, 2'd0, 1'b0);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        $display("[TB] overflow shift and invalid code");
        press(4'd9);
        press(4'd4);
        press(4'd5);
        checkOutput("entry_945", 4'd9, 4'd4, 4'd5, 1'b1, 2'd3, 1'b0);
        press(4'd2);
        checkOutput("entry_452", 4'd4, 4'd5, 4'd2, 1'b1, 2'd3, 1'b0);
        press(4'hC);
        checkOutput("bad_code", 4'd4, 4'd5, 4'd2, 1'b1, 2'd3, 1'b0);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("cancel", 4'd0, 4'd0, 4'd0, 1'b1, 2'd0, 1'b0);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        $display("[TB] rejected start and empty start");
        press(4'd0);
        press(4'd7);
        press(4'd5);
        checkOutput("entry_075", 4'd0, 4'd7, 4'd5, 1'b1, 2'd3, 1'b0);
        applyStimulus(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("err_pulse", 4'd0, 4'd0, 4'd0, 1'b1, 2'd0, 1'b1);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("err_end", 4'd0, 4'd0, 4'd0, 1'b1, 2'd0, 1'b0);
        applyStimulus(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("zero_start", 4'd0, 4'd0, 4'd0, 1'b1, 2'd0, 1'b0);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("zero_start_after", 4'd0, 4'd0, 4'd0, 1'b1, 2'd0, 1'b0);

        $display("[TB] seconds-tens at limit loads");
        press(4'd5);
        press(4'd0);
        applyStimulus(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("load_050", 4'd0, 4'd5, 4'd0, 1'b0, 2'd2, 1'b0);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("load_050_end", 4'd0, 4'd0, 4'd0, 1'b1, 2'd0, 1'b0);

        $display("[TB] same-cycle priority");
        press(4'd2);
        press(4'd1);
        applyStimulus(4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("cancel_over_start", 4'd0, 4'd0, 4'd0, 1'b1, 2'd0, 1'b0);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("cancel_over_start_after", 4'd0, 4'd0, 4'd0, 1'b1, 2'd0, 1'b0);
        press(4'd3);
        applyStimulus(4'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("start_over_key", 4'd0, 4'd0, 4'd3, 1'b0, 2'd1, 1'b0);
        applyStimulus(4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("start_over_key_end", 4'd0, 4'd0, 4'd0, 1'b1, 2'd0, 1'b0);

        $display("[TB] counting gate");
        press(4'd4);
        applyStimulus(4'd6, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("count_key", 4'd0, 4'd0, 4'd4, 1'b1, 2'd1, 1'b0);
        applyStimulus(4'd6, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("count_start", 4'd0, 4'd0, 4'd4, 1'b1, 2'd1, 1'b0);
        applyStimulus(4'd6, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("count_cancel", 4'd0, 4'd0, 4'd4, 1'b1, 2'd1, 1'b0);
        applyStimulus(4'd6, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("held_key_after_count", 4'd0, 4'd0, 4'd4, 1'b1, 2'd1, 1'b0);
        applyStimulus(4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        press(4'd7);
        checkOutput("key_after_count", 4'd0, 4'd4, 4'd7, 1'b1, 2'd2, 1'b0);

        $display("[TB] reset during LOAD");
        applyStimulus(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("load_047", 4'd0, 4'd4, 4'd7, 1'b0, 2'd2, 1'b0);
        #2;
        clearn = 1'b0;
        #1;
        checkOutput("async_reset_in_load", 4'd0, 4'd0, 4'd0, 1'b1, 2'd0, 1'b0);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        clearn = 1'b1;
        tick();
        checkOutput("after_reset_release", 4'd0, 4'd0, 4'd0, 1'b1, 2'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
        $finish;
    end

endmodule
